// File: rtl/sudoku_check_sequencer_if.sv
// Bundle between the Sudoku check sequencer, the grid read port and the status pins.
// The slave modport is the sequencer and the master modport is its environment.
interface sudoku_check_sequencer_if;
  // start is taken only while busy=0. A taken start holds busy=1 until the scan ends.
  // rd_en=1 marks a read of (rd_row, rd_col), and rd_data returns it on the next cycle.
  // The read port has no back-pressure.
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_unit;
  logic [3:0] err_index;
  logic [3:0] err_digit;
  logic       rd_en;
  logic [3:0] rd_row;
  logic [3:0] rd_col;
  logic [3:0] rd_data;
  logic       incomplete;
  logic [6:0] empty_count;
  logic [1:0] dbg_state;

  modport master (
    output start, rd_data,
    input  busy, done, err, err_unit, err_index, err_digit,
    input  rd_en, rd_row, rd_col, incomplete, empty_count, dbg_state
  );

  modport slave (
    input  start, rd_data,
    output busy, done, err, err_unit, err_index, err_digit,
    output rd_en, rd_row, rd_col, incomplete, empty_count, dbg_state
  );
endinterface

// File: rtl/sudoku_check_sequencer.sv
// Walks the 9x9 grid through all rows, then all columns, then all boxes, and stops on the first violation.
// The optional zero-cell accounting is enabled by defining SUDOKU_COMPLETE_CHECK_EN.
module sudoku_check_sequencer (
  input  logic                           clk,
  input  logic                           rst,
  sudoku_check_sequencer_if.slave        bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_LAST = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] unit_q, unit_d;
  logic [3:0] cell_q, cell_d;
  logic       pipe_valid_q, pipe_valid_d;
  logic       pipe_first_q, pipe_first_d;
  logic [1:0] pipe_phase_q, pipe_phase_d;
  logic [3:0] pipe_unit_q, pipe_unit_d;
  logic [8:0] mask_q, mask_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] err_unit_q, err_unit_d;
  logic [3:0] err_index_q, err_index_d;
  logic [3:0] err_digit_q, err_digit_d;

  logic       accept;
  logic       scan_last;
  logic       err_hit;
  logic [8:0] mask_base;
  logic [8:0] digit_bit;
  logic [3:0] addr_row;
  logic [3:0] addr_col;

  assign accept    = (state_q == S_IDLE) && bus.start;
  assign scan_last = (phase_q == 2'd2) && (unit_q == 4'd8) && (cell_q == 4'd8);

  // The checker lags the address by one cycle. pipe_* describe the cell now on rd_data.
  always_comb begin
    mask_base = pipe_first_q ? 9'd0 : mask_q;
    digit_bit = 9'd0;
    if ((bus.rd_data >= 4'd1) && (bus.rd_data <= 4'd9))
      digit_bit = 9'd1 << (bus.rd_data - 4'd1);
    err_hit = pipe_valid_q &&
              ((bus.rd_data > 4'd9) || ((mask_base & digit_bit) != 9'd0));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_SCAN;
      S_SCAN: begin
        if (err_hit)        state_d = S_IDLE;
        else if (scan_last) state_d = S_LAST;
      end
      S_LAST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.rd_en     = (state_q == S_SCAN);
    bus.dbg_state = state_q;
  end

  always_comb begin
    addr_row = 4'd0;
    addr_col = 4'd0;
    unique case (phase_q)
      2'd0: begin
        addr_row = unit_q;
        addr_col = cell_q;
      end
      2'd1: begin
        addr_row = cell_q;
        addr_col = unit_q;
      end
      default: begin
        addr_row = (unit_q / 4'd3) * 4'd3 + cell_q / 4'd3;
        addr_col = (unit_q % 4'd3) * 4'd3 + cell_q % 4'd3;
      end
    endcase
    bus.rd_row = addr_row;
    bus.rd_col = addr_col;
  end

  // The counters stop advancing after the final address or an error, so the address stays put.
  always_comb begin
    phase_d = phase_q;
    unit_d  = unit_q;
    cell_d  = cell_q;
    if (accept) begin
      phase_d = 2'd0;
      unit_d  = 4'd0;
      cell_d  = 4'd0;
    end else if ((state_q == S_SCAN) && !err_hit && !scan_last) begin
      if (cell_q == 4'd8) begin
        cell_d = 4'd0;
        if (unit_q == 4'd8) begin
          unit_d  = 4'd0;
          phase_d = phase_q + 2'd1;
        end else begin
          unit_d = unit_q + 4'd1;
        end
      end else begin
        cell_d = cell_q + 4'd1;
      end
    end
  end

  always_comb begin
    pipe_valid_d = (state_q == S_SCAN) && !err_hit;
    pipe_first_d = (cell_q == 4'd0);
    pipe_phase_d = phase_q;
    pipe_unit_d  = unit_q;

    mask_d = mask_q;
    if (accept)            mask_d = 9'd0;
    else if (pipe_valid_q) mask_d = mask_base | digit_bit;

    done_d      = done_q;
    err_d       = err_q;
    err_unit_d  = err_unit_q;
    err_index_d = err_index_q;
    err_digit_d = err_digit_q;
    if (accept) begin
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_unit_d  = 2'd0;
      err_index_d = 4'd0;
      err_digit_d = 4'd0;
    end else begin
      if (err_hit) begin
        done_d      = 1'b1;
        err_d       = 1'b1;
        err_unit_d  = pipe_phase_q;
        err_index_d = pipe_unit_q;
        err_digit_d = bus.rd_data;
      end
      if (state_q == S_LAST) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= 2'd0;
      unit_q       <= 4'd0;
      cell_q       <= 4'd0;
      pipe_valid_q <= 1'b0;
      pipe_first_q <= 1'b0;
      pipe_phase_q <= 2'd0;
      pipe_unit_q  <= 4'd0;
      mask_q       <= 9'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_unit_q   <= 2'd0;
      err_index_q  <= 4'd0;
      err_digit_q  <= 4'd0;
    end else begin
      phase_q      <= phase_d;
      unit_q       <= unit_d;
      cell_q       <= cell_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_first_q <= pipe_first_d;
      pipe_phase_q <= pipe_phase_d;
      pipe_unit_q  <= pipe_unit_d;
      mask_q       <= mask_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_unit_q   <= err_unit_d;
      err_index_q  <= err_index_d;
      err_digit_q  <= err_digit_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_unit  = err_unit_q;
  assign bus.err_index = err_index_q;
  assign bus.err_digit = err_digit_q;

`ifdef SUDOKU_COMPLETE_CHECK_EN
  logic       incomplete_q, incomplete_d;
  logic [6:0] empty_count_q, empty_count_d;
  logic       zero_seen;

  // Counting only in the row phase means each cell is counted once.
  always_comb begin
    zero_seen     = pipe_valid_q && (bus.rd_data == 4'd0);
    incomplete_d  = incomplete_q;
    empty_count_d = empty_count_q;
    if (accept) begin
      incomplete_d  = 1'b0;
      empty_count_d = 7'd0;
    end else if (zero_seen) begin
      incomplete_d = 1'b1;
      if (pipe_phase_q == 2'd0) empty_count_d = empty_count_q + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      incomplete_q  <= 1'b0;
      empty_count_q <= 7'd0;
    end else begin
      incomplete_q  <= incomplete_d;
      empty_count_q <= empty_count_d;
    end
  end

  assign bus.incomplete  = incomplete_q;
  assign bus.empty_count = empty_count_q;
`else
  assign bus.incomplete  = 1'b0;
  assign bus.empty_count = 7'd0;
`endif
endmodule

// File: tb/tb_sudoku_check_sequencer.sv
// Bench for sudoku_check_sequencer: it uses random and directed grids and checks them against a
// walk-the-units reference. The expectations follow SUDOKU_COMPLETE_CHECK_EN.
module tb_sudoku_check_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sudoku_check_sequencer_if bus();
  sudoku_check_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [3:0] grid [0:8][0:8];
  logic [3:0] pos_r [0:242];
  logic [3:0] pos_c [0:242];
  logic [7:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_n, exp_unit, exp_index, exp_digit, exp_zero, exp_rzero;

  // Grid register array: synchronous read, data valid the cycle after rd_en
  always @(posedge clk) begin
    if (rst)             bus.rd_data <= 4'd0;
    else if (bus.rd_en)  bus.rd_data <= grid[bus.rd_row][bus.rd_col];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string where);
    check_eq({where, "_busy"},        32'(bus.busy), 0);
    check_eq({where, "_done"},        32'(bus.done), 0);
    check_eq({where, "_err"},         32'(bus.err), 0);
    check_eq({where, "_err_unit"},    32'(bus.err_unit), 0);
    check_eq({where, "_err_index"},   32'(bus.err_index), 0);
    check_eq({where, "_err_digit"},   32'(bus.err_digit), 0);
    check_eq({where, "_rd_en"},       32'(bus.rd_en), 0);
    check_eq({where, "_rd_row"},      32'(bus.rd_row), 0);
    check_eq({where, "_rd_col"},      32'(bus.rd_col), 0);
    check_eq({where, "_incomplete"},  32'(bus.incomplete), 0);
    check_eq({where, "_empty_count"}, 32'(bus.empty_count), 0);
  endtask

  // Reference: visit rows, columns and boxes in order, tracking digits seen per unit
  task automatic ref_walk();
    logic [9:0] seen;
    int v;
    seen = '0;
    exp_n = -1; exp_unit = 0; exp_index = 0; exp_digit = 0; exp_zero = 0; exp_rzero = 0;
    for (int i = 0; i < 243; i++) begin
      if (i % 9 == 0) seen = '0;
      v = int'(grid[pos_r[i]][pos_c[i]]);
      if (v == 0) begin
        exp_zero++;
        if (i < 81) exp_rzero++;
      end else if (v > 9 || seen[v]) begin
        exp_n = i; exp_unit = i / 81; exp_index = (i / 9) % 9; exp_digit = v;
        break;
      end else begin
        seen[v] = 1'b1;
      end
    end
  endtask

  task automatic make_base();
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        grid[r][c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
  endtask

  task automatic make_valid();
    int d [0:8];
    int roff [0:2];
    int coff [0:2];
    int j, t, rr, cc;
    for (int i = 0; i < 9; i++) d[i] = i + 1;
    for (int i = 8; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = d[i]; d[i] = d[j]; d[j] = t;
    end
    for (int b = 0; b < 3; b++) begin
      roff[b] = int'($urandom_range(0, 2));
      coff[b] = int'($urandom_range(0, 2));
    end
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        rr = (r / 3) * 3 + ((r % 3 + roff[r / 3]) % 3);
        cc = (c / 3) * 3 + ((c % 3 + coff[c / 3]) % 3);
        grid[r][c] = 4'(d[(rr * 3 + rr / 3 + cc) % 9]);
      end
  endtask

  task automatic run_check(input int restart_at, input int rst_at);
    int reads, busy_cnt, done_cyc, exp_done;
    logic [7:0] got;
    ref_walk();
    exp_q.delete();
    reads = (exp_n < 0) ? 243 : ((exp_n + 2 > 243) ? 243 : exp_n + 2);
    for (int i = 0; i < reads; i++) exp_q.push_back({pos_r[i], pos_c[i]});
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    busy_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
      if (bus.busy) busy_cnt++;
      if (bus.rd_en) begin
        if (exp_q.size() == 0) check_eq("extra_read", 1, 0);
        else begin
          got = {bus.rd_row, bus.rd_col};
          check_eq("rd_addr", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      if (bus.done) done_cyc = c;
      bus.start = (c == restart_at);
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    exp_done = (exp_n < 0) ? 245 : exp_n + 3;
    check_eq("done_seen", 32'(done_cyc != 0), 1);
    check_eq("done_cycle", 32'(done_cyc), 32'(exp_done));
    check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_done - 1));
    check_eq("reads_left", 32'(exp_q.size()), 0);
    check_eq("busy_after", 32'(bus.busy), 0);
    check_eq("rd_en_after", 32'(bus.rd_en), 0);
    check_eq("err", 32'(bus.err), 32'(exp_n >= 0));
    check_eq("err_unit", 32'(bus.err_unit), 32'(exp_unit));
    check_eq("err_index", 32'(bus.err_index), 32'(exp_index));
    check_eq("err_digit", 32'(bus.err_digit), 32'(exp_digit));
`ifdef SUDOKU_COMPLETE_CHECK_EN
    check_eq("incomplete", 32'(bus.incomplete), 32'(exp_zero > 0));
    check_eq("empty_count", 32'(bus.empty_count), 32'(exp_rzero));
`else
    check_eq("incomplete", 32'(bus.incomplete), 0);
    check_eq("empty_count", 32'(bus.empty_count), 0);
`endif
    repeat (3) @(negedge clk);
    check_eq("done_sticky", 32'(bus.done), 1);
    check_eq("busy_idle", 32'(bus.busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    idx = 0;
    for (int p = 0; p < 3; p++)
      for (int u = 0; u < 9; u++)
        for (int k = 0; k < 9; k++) begin
          if (p == 0)      begin pos_r[idx] = 4'(u); pos_c[idx] = 4'(k); end
          else if (p == 1) begin pos_r[idx] = 4'(k); pos_c[idx] = 4'(u); end
          else begin
            pos_r[idx] = 4'(3 * (u / 3) + k / 3);
            pos_c[idx] = 4'(3 * (u % 3) + k % 3);
          end
          idx++;
        end

    // Clock/reset
    rst = 1'b1; bus.start = 1'b0;
    make_base();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    make_valid();
    run_check(0, 0);

    make_base();
    grid[2][0] = 4'd5;
    run_check(0, 0);

    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) grid[r][c] = 4'(c + 1);
    run_check(0, 0);

    make_valid();
    grid[0][0] = 4'd12;
    run_check(0, 0);

    make_valid();
    run_check(0, 100);

    make_valid();
    run_check(50, 0);

    make_valid();
    grid[0][0] = 4'd0; grid[4][5] = 4'd0; grid[8][8] = 4'd0;
    run_check(0, 0);

    make_valid();
    grid[8][8] = grid[8][0];
    run_check(0, 0);

    for (int t = 0; t < 8; t++) begin
      make_valid();
      for (int m = int'($urandom_range(0, 3)); m > 0; m--)
        grid[$urandom_range(0, 8)][$urandom_range(0, 8)] =
          ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      run_check(0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
